// File: rtl/dff_chain_pkg.sv
// Shared types and helpers for the DFF chain controller.
// Optional consistency check is enabled by defining DFF_CHAIN_CHK_EN.
package dff_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Counter must hold WIDTH+DEPTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width, input int depth);
        return (width + depth > 2) ? $clog2(width + depth) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone valid wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
    import dff_chain_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant    = 2'b00;
        grant_id = REQ0;
        if (enable && (valid != 2'b00)) begin
            if (valid == 2'b11) begin
                grant_id = ~last_grant;
            end else if (valid[1]) begin
                grant_id = REQ1;
            end else begin
                grant_id = REQ0;
            end
            grant = (grant_id == REQ1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dff_chain_ctrl.sv
// Shares one serial DFF delay chain between two requesters: serialises a word
// LSB-first, deserialises the echo. Define DFF_CHAIN_CHK_EN for chk_err.
module dff_chain_ctrl
    import dff_chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             chain_d,
    input  logic             chain_q,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,
`ifdef DFF_CHAIN_CHK_EN
    output logic             chk_err,
`endif
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH, DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_TX_END   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_RX_START = CNT_W'(DEPTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic             last_grant;
    logic             id_q;
    logic [1:0]       grant;
    logic             grant_id;
    logic             accept;

    // Handshakes: a word moves when valid && ready on a rising edge. Requesters
    // hold valid/data until ready; ready is only ever high in IDLE. The response
    // is held in RESP until rsp_valid && rsp_ready.
    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign req0_ready = rstn & grant[0];
    assign req1_ready = rstn & grant[1];
    assign accept     = |grant;

    assign chain_d   = ((state == SHIFT) && (cnt < CNT_TX_END)) ? tx_shift[0] : 1'b0;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rx_shift;
    assign rsp_id    = id_q;
    assign busy      = (state != IDLE);

    always_comb begin
        rx_next          = rx_shift >> 1;
        rx_next[WIDTH-1] = chain_q;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            last_grant <= REQ1;
            id_q       <= REQ0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift   <= (grant_id == REQ1) ? req1_data : req0_data;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= '0;
                    end
                end
                SHIFT: begin
                    tx_shift <= tx_shift >> 1;
                    // The first transmitted bit reaches chain_q DEPTH cycles later.
                    if (cnt >= CNT_RX_START) begin
                        rx_shift <= rx_next;
                    end
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef DFF_CHAIN_CHK_EN
    logic [WIDTH-1:0] tx_copy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_copy <= '0;
        end else if ((state == IDLE) && accept) begin
            tx_copy <= (grant_id == REQ1) ? req1_data : req0_data;
        end
    end

    assign chk_err = (state == RESP) && (rx_shift != tx_copy);
`endif

endmodule

// File: tb/tb_dff_chain_ctrl.sv
// Directed bench for dff_chain_ctrl driving a real 4-stage DFF chain.
// Checks chk_err as well when DFF_CHAIN_CHK_EN is defined.
module tb_dff_chain_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             chain_d, chain_q;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0] rsp_data;
    logic             force_q0;
`ifdef DFF_CHAIN_CHK_EN
    logic             chk_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;

    dff_chain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .chain_d    (chain_d),
        .chain_q    (chain_q),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
`ifdef DFF_CHAIN_CHK_EN
        .chk_err    (chk_err),
`endif
        .busy       (busy)
    );

    // Attached delay chain, cleared by the shared reset.
    logic [DEPTH-1:0] chain;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) chain <= '0;
        else       chain <= {chain[DEPTH-2:0], chain_d};
    end
    assign chain_q = force_q0 ? 1'b0 : chain[DEPTH-1];

    // Cycle counter and accept-edge timestamp for latency measurement.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req0_ready || req1_ready) acc_cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic id, input logic [WIDTH-1:0] d);
        int n = 0;
        if (id) begin req1_data = d; req1_valid = 1'b1; end
        else    begin req0_data = d; req0_valid = 1'b1; end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check("send_ready", id ? req1_ready : req0_ready, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [WIDTH-1:0] exp_data, input logic exp_id);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk); n++;
        end
        check({tag, "_seen"}, rsp_valid, 1);
        check({tag, "_lat"}, cyc - acc_cyc, 12);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_id"}, rsp_id, exp_id);
    endtask

    task automatic do_reset();
        @(negedge clk); rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] bits;
        int               seen;

        rstn = 1'b0; rsp_ready = 1'b1; force_q0 = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'h00; req1_data = 8'h00;

        // Reset: outputs low even with valids asserted.
        repeat (3) @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_chain_d", chain_d, 0);
`ifdef DFF_CHAIN_CHK_EN
        check("rst_chk_err", chk_err, 0);
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Single request 0xA5.
        req0_data = 8'hA5; req0_valid = 1'b1; #1;
        check("s1_ready0", req0_ready, 1);
        check("s1_ready1", req1_ready, 0);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk);
        check("s1_ready_pulse", req0_ready, 0);
        check("s1_busy", busy, 1);
        for (int k = 0; k < WIDTH; k++) begin
            bits[k] = chain_d;
            @(negedge clk);
        end
        check("s1_serial", bits, 8'hA5);
        check("s1_tail_d", chain_d, 0);
        wait_rsp("s1", 8'hA5, 1'b0);
        @(negedge clk);
        check("s1_done", rsp_valid, 0);

        // Tie right after reset: req0 first, then req1.
        do_reset();
        req0_data = 8'h3C; req1_data = 8'hC3;
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        check("tie_ready0", req0_ready, 1);
        check("tie_ready1", req1_ready, 0);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk);
        check("tie_ignore1", req1_ready, 0);
        wait_rsp("tie_a", 8'h3C, 1'b0);
        @(negedge clk);
        check("tie_gap_busy", busy, 0);
        check("tie_gap_ready1", req1_ready, 1);
        @(posedge clk); #1; req1_valid = 1'b0;
        @(negedge clk);
        check("tie_busy_again", busy, 1);
        wait_rsp("tie_b", 8'hC3, 1'b1);
        @(negedge clk);

        // Back-pressure: response held for 5 cycles.
        rsp_ready = 1'b0;
        send(1'b0, 8'h96);
        wait_rsp("bp", 8'h96, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 8'h96);
            check("bp_id", rsp_id, 0);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_done_valid", rsp_valid, 0);
        check("bp_done_busy", busy, 0);

        // Reset in the middle of SHIFT aborts the transaction.
        send(1'b1, 8'h77);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1);
        rstn = 1'b0; #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_chain_d", chain_d, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_rsp_id", rsp_id, 0);
        @(negedge clk); rstn = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_no_rsp", seen, 0);
        send(1'b1, 8'h5A);
        wait_rsp("post_rst", 8'h5A, 1'b1);
        @(negedge clk);

        // Fairness: both valids held for four transactions.
        req0_data = 8'h11; req1_data = 8'h22;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_rsp("fair", (t % 2) ? 8'h22 : 8'h11, t[0]);
            if (t == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
        end
        check("fair_idle", busy, 0);

        // Stuck-at-zero chain output returns 0x00.
        force_q0 = 1'b1;
        send(1'b0, 8'hFF);
        wait_rsp("stuck", 8'h00, 1'b0);
`ifdef DFF_CHAIN_CHK_EN
        check("stuck_chk_err", chk_err, 1);
`endif
        @(negedge clk);
`ifdef DFF_CHAIN_CHK_EN
        check("chk_err_cleared", chk_err, 0);
`endif
        force_q0 = 1'b0;
        send(1'b0, 8'h81);
        wait_rsp("good", 8'h81, 1'b0);
`ifdef DFF_CHAIN_CHK_EN
        check("good_chk_err", chk_err, 0);
`endif
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dff_chain_ctrl.md
Name: dff_chain_ctrl

Overview:
- Controller that shares one serial DFF delay chain (DEPTH stages, shifts every clk, no enable) between two requesters.
- Accepts a WIDTH-bit word from the granted requester and serialises it LSB-first onto chain_d.
- Deserialises the word returned on chain_q and presents it on a response port with the requester ID.
- Sits between requester logic and the chain instance; the chain shares clk and rstn with this block.

Parameters:
- WIDTH, 8: data word width in bits; range 1 to 32.
- DEPTH, 4: number of stages in the attached chain, which is its latency in cycles; range 1 to 16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- chain_d  output  1  serial bit into the chain.
- chain_q  input  1  serial bit out of the chain.
- rsp_valid  output  1  response word available.
- rsp_data  output  WIDTH  returned word.
- rsp_id  output  1  requester that owns the response.
- rsp_ready  input  1  consumer accepts the response.
- busy  output  1  transaction in progress (state is not IDLE).

Behaviour:
- Reset: clk and rstn, with rstn asynchronous active-low. All outputs are 0 while rstn is low. State returns to IDLE, cnt=0, last_grant=1, so req0 wins the first tie.
- States:
  - IDLE: grant is computed from valids and last_grant.
  - SHIFT: covers cnt = 0 .. WIDTH+DEPTH-1.
  - RESP: holds the response until it is taken.
- IDLE:
  - reqN_ready = granted AND reqN_valid. The ready is combinational from registered state and the valids; there is no combinational path from data.
  - On accept: latch data into tx_shift, latch the ID, set last_grant=ID, cnt=0, go to SHIFT.
  - Arbitration: round-robin. A lone valid is granted. With both valid, grant the requester that is not last_grant.
- SHIFT:
  - chain_d = tx_shift[0] while cnt < WIDTH, otherwise 0. tx_shift shifts right each cycle.
  - For cnt in DEPTH .. DEPTH+WIDTH-1, sample chain_q into rx_shift, shifting in at the MSB. After WIDTH samples, rx_shift holds the word in original bit order.
  - cnt increments each cycle. At cnt = DEPTH+WIDTH-1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are registered and stable.
  - On rsp_valid && rsp_ready: go to IDLE on the next edge.
  - A new accept cannot occur in that same cycle; it is possible from the following IDLE cycle.
- Latency: accept edge to rsp_valid high is WIDTH+DEPTH cycles.
- reqN_ready is 0 outside IDLE; valids held during that time are ignored.
- Requesters must hold valid and data until ready.
- cnt width is clog2(WIDTH+DEPTH). There is no wrap-around, because cnt exits at its terminal value.
- Reset mid-operation: the transaction is aborted with no response. The chain contents are also cleared by the shared rstn.

Optional Feature:
- Macro: DFF_CHAIN_CHK_EN.
- With the macro defined:
  - Extra output chk_err (1 bit).
  - In RESP, chk_err = (rx word != latched tx word). It is valid together with rsp_valid and is cleared on leaving RESP.
  - The block keeps an original copy of the tx word (WIDTH flops).
- Without the macro: no chk_err port and no copy register.

Decomposition:
- Package dff_chain_pkg holds:
  - state enum {IDLE, SHIFT, RESP};
  - localparam helper for counter width (clog2 of WIDTH+DEPTH);
  - requester ID constants REQ0=0, REQ1=1.
- Sub-module rr_arb2:
  - 2-way round-robin arbiter.
  - Inputs: valid[1:0], last_grant, enable.
  - Outputs: one-hot grant and grant_id.
- All remaining logic (FSM, counter, shift registers) lives in dff_chain_ctrl.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4, driving a real 4-stage chain.
- Single request, data 0xA5:
  - req0_valid=1, data 0xA5 -> req0_ready pulses one cycle.
  - chain_d over cnt 0..7 is 1,0,1,0,0,1,0,1.
  - rsp_valid rises 12 cycles after accept, with rsp_data=0xA5, rsp_id=0.
- Tie after reset, data 0x3C and 0xC3:
  - req0=0x3C and req1=0xC3 asserted together -> req0 served first (rsp 0x3C, id 0).
  - Then req1 is served (rsp 0xC3, id 1).
  - busy is low for exactly one cycle between the two transactions.
- Back-pressure:
  - rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id are held stable.
  - Both reqN_ready stay 0; transaction completes on the cycle rsp_ready rises.
- Reset mid-SHIFT:
  - rstn pulled low at cnt=3 -> all outputs go to 0 immediately, and no rsp_valid follows.
  - After release, req1=0x5A completes normally (12-cycle latency, id 1).
- Fairness, data 0x11/0x22:
  - Both valids held high for 4 transactions -> rsp_id sequence is 0,1,0,1.
- DFF_CHAIN_CHK_EN:
  - Force chain_q=0 and send 0xFF -> rsp_data=0x00, chk_err=1 in RESP.
  - A normal 0x81 transaction -> chk_err=0.
